// File: rtl/recon_dma_desc_sched_pkg.sv
// rtl/recon_dma_desc_sched_pkg.sv - shared constants, DMA error codes and round-robin helper
package recon_dma_desc_sched_pkg;

    localparam int DEF_PORTS           = 2;
    localparam int DEF_ADDR_WIDTH      = 34;
    localparam int DEF_LEN_WIDTH       = 20;
    localparam int DEF_S_TAG_WIDTH     = 4;
    localparam int DEF_TAG_WIDTH       = 8;
    localparam int DEF_MAX_OUTSTANDING = 8;

    // DMA completion error code width and values, shared with the recon controller
    localparam int DMA_ERR_WIDTH = 4;

    typedef enum logic [DMA_ERR_WIDTH-1:0] {
        DMA_ERR_NONE    = 4'd0,
        DMA_ERR_TIMEOUT = 4'd1,
        DMA_ERR_BUS     = 4'd2,
        DMA_ERR_LEN     = 4'd3
    } dma_err_e;

    // Port that takes highest priority after port g was granted
    function automatic int rr_next(input int g, input int ports);
        return (g == ports - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/recon_dma_desc_sched_if.sv
// rtl/recon_dma_desc_sched_if.sv - requester, status and DMA descriptor/status bundle
interface recon_dma_desc_sched_if
    import recon_dma_desc_sched_pkg::*;
#(
    parameter int PORTS       = DEF_PORTS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
    parameter int S_TAG_WIDTH = DEF_S_TAG_WIDTH,
    parameter int TAG_WIDTH   = DEF_TAG_WIDTH
);
    logic [PORTS*ADDR_WIDTH-1:0]    s_axis_desc_addr;
    logic [PORTS*LEN_WIDTH-1:0]     s_axis_desc_len;
    logic [PORTS*S_TAG_WIDTH-1:0]   s_axis_desc_tag;
    logic [PORTS-1:0]               s_axis_desc_valid;
    logic [PORTS-1:0]               s_axis_desc_ready;

    logic [PORTS*S_TAG_WIDTH-1:0]   m_axis_status_tag;
    logic [PORTS*DMA_ERR_WIDTH-1:0] m_axis_status_error;
    logic [PORTS-1:0]               m_axis_status_valid;

    logic [ADDR_WIDTH-1:0]          m_axis_read_desc_addr;
    logic [LEN_WIDTH-1:0]           m_axis_read_desc_len;
    logic [TAG_WIDTH-1:0]           m_axis_read_desc_tag;
    logic                           m_axis_read_desc_valid;
    logic                           m_axis_read_desc_ready;

    logic [TAG_WIDTH-1:0]           s_axis_read_desc_status_tag;
    logic [DMA_ERR_WIDTH-1:0]       s_axis_read_desc_status_error;
    logic                           s_axis_read_desc_status_valid;

    modport master (
        input  s_axis_desc_addr, s_axis_desc_len, s_axis_desc_tag, s_axis_desc_valid,
        output s_axis_desc_ready,
        output m_axis_status_tag, m_axis_status_error, m_axis_status_valid,
        output m_axis_read_desc_addr, m_axis_read_desc_len, m_axis_read_desc_tag, m_axis_read_desc_valid,
        input  m_axis_read_desc_ready,
        input  s_axis_read_desc_status_tag, s_axis_read_desc_status_error, s_axis_read_desc_status_valid
    );

    modport slave (
        output s_axis_desc_addr, s_axis_desc_len, s_axis_desc_tag, s_axis_desc_valid,
        input  s_axis_desc_ready,
        input  m_axis_status_tag, m_axis_status_error, m_axis_status_valid,
        input  m_axis_read_desc_addr, m_axis_read_desc_len, m_axis_read_desc_tag, m_axis_read_desc_valid,
        output m_axis_read_desc_ready,
        output s_axis_read_desc_status_tag, s_axis_read_desc_status_error, s_axis_read_desc_status_valid
    );
endinterface

// File: rtl/recon_rr_arbiter.sv
// rtl/recon_rr_arbiter.sv - combinational round-robin grant with pointer advanced on accept
module recon_rr_arbiter
    import recon_dma_desc_sched_pkg::*;
#(
    parameter int PORTS = 2,
    localparam int IW   = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] request,
    input  logic             advance,
    output logic [PORTS-1:0] grant,
    output logic [IW-1:0]    grant_idx
);
    logic [IW-1:0] ptr;

    // First requester at or after the pointer wins
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < PORTS; off++) begin
            idx = (int'(ptr) + off) % PORTS;
            if (!found && request[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

    // Priority moves just past the granted port only when the grant is taken
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= IW'(rr_next(int'(grant_idx), PORTS));
    end
endmodule

// File: rtl/recon_dma_desc_sched.sv
// rtl/recon_dma_desc_sched.sv - shares one DMA read-descriptor channel among requesters with tag remapping
module recon_dma_desc_sched
    import recon_dma_desc_sched_pkg::*;
#(
    parameter int PORTS           = DEF_PORTS,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH       = DEF_LEN_WIDTH,
    parameter int S_TAG_WIDTH     = DEF_S_TAG_WIDTH,
    parameter int TAG_WIDTH       = DEF_TAG_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    localparam int SW = $clog2(MAX_OUTSTANDING),
    localparam int PW = $clog2(PORTS),
    localparam int CW = SW + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    recon_dma_desc_sched_if.master  bus,
    output logic [CW-1:0]           outstanding,
    output logic                    stray_status
);
    logic [MAX_OUTSTANDING-1:0] busy;
    logic [PW-1:0]              slot_port [MAX_OUTSTANDING];
    logic [S_TAG_WIDTH-1:0]     slot_stag [MAX_OUTSTANDING];

    logic [SW-1:0]    free_idx;
    logic             slot_free;
    logic             can_load;
    logic             accept;
    logic [PORTS-1:0] grant;
    logic [PW-1:0]    gidx;
    logic [SW-1:0]    st_slot;
    logic             st_hit;
    logic             st_stray;

    // Lowest free slot; a slot freed this cycle is still busy here, so it is not reused until next cycle
    always_comb begin
        free_idx = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--)
            if (!busy[i]) free_idx = SW'(i);
    end

    assign slot_free = ~&busy;
    assign can_load  = (!bus.m_axis_read_desc_valid || bus.m_axis_read_desc_ready) && slot_free && !rst;
    assign accept    = can_load && |grant;
    assign bus.s_axis_desc_ready = can_load ? grant : '0;

    recon_rr_arbiter #(.PORTS(PORTS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .request   (bus.s_axis_desc_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign st_slot  = bus.s_axis_read_desc_status_tag[SW-1:0];
    assign st_hit   = bus.s_axis_read_desc_status_valid
                      && (bus.s_axis_read_desc_status_tag < TAG_WIDTH'(MAX_OUTSTANDING))
                      && busy[st_slot];
    assign st_stray = bus.s_axis_read_desc_status_valid && !st_hit;

    // Descriptor output register: loads on accept, holds while stalled, clears once taken
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_axis_read_desc_valid <= 1'b0;
            bus.m_axis_read_desc_addr  <= '0;
            bus.m_axis_read_desc_len   <= '0;
            bus.m_axis_read_desc_tag   <= '0;
        end else if (accept) begin
            bus.m_axis_read_desc_valid <= 1'b1;
            bus.m_axis_read_desc_addr  <= bus.s_axis_desc_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
            bus.m_axis_read_desc_len   <= bus.s_axis_desc_len[gidx*LEN_WIDTH +: LEN_WIDTH];
            bus.m_axis_read_desc_tag   <= TAG_WIDTH'(free_idx);
        end else if (bus.m_axis_read_desc_ready) begin
            bus.m_axis_read_desc_valid <= 1'b0;
        end
    end

    // Outstanding table: completion frees its slot, accept claims the lowest free one (never the same slot)
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (st_hit)
                busy[st_slot] <= 1'b0;
            if (accept) begin
                busy[free_idx]      <= 1'b1;
                slot_port[free_idx] <= gidx;
                slot_stag[free_idx] <= bus.s_axis_desc_tag[gidx*S_TAG_WIDTH +: S_TAG_WIDTH];
            end
        end
    end

    // Completion routing: one-cycle pulse to the owning port with its original tag
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_axis_status_valid <= '0;
            bus.m_axis_status_tag   <= '0;
            bus.m_axis_status_error <= '0;
        end else begin
            bus.m_axis_status_valid <= '0;
            if (st_hit) begin
                bus.m_axis_status_valid[slot_port[st_slot]] <= 1'b1;
                bus.m_axis_status_tag[slot_port[st_slot]*S_TAG_WIDTH +: S_TAG_WIDTH] <= slot_stag[st_slot];
                bus.m_axis_status_error[slot_port[st_slot]*DMA_ERR_WIDTH +: DMA_ERR_WIDTH] <=
                    bus.s_axis_read_desc_status_error;
            end
        end
    end

    // Busy count and sticky stray-completion flag
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding  <= '0;
            stray_status <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(st_hit);
            if (st_stray)
                stray_status <= 1'b1;
        end
    end
endmodule

// File: tb/tb_recon_dma_desc_sched.sv
// tb/tb_recon_dma_desc_sched.sv - directed self-checking bench for recon_dma_desc_sched
module tb_recon_dma_desc_sched;
    import recon_dma_desc_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] outstanding;
    logic       stray_status;
    int         tests = 0;
    int         failed = 0;

    localparam logic [33:0] A0 = 34'h1_0000_0000;
    localparam logic [33:0] A1 = 34'h0_2345_6000;

    recon_dma_desc_sched_if bus ();

    recon_dma_desc_sched dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.master),
        .outstanding  (outstanding),
        .stray_status (stray_status)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.s_axis_desc_addr              = {A1, A0};
        bus.s_axis_desc_len               = {20'd512, 20'd4096};
        bus.s_axis_desc_tag               = {4'hB, 4'h3};
        bus.s_axis_desc_valid             = 2'b00;
        bus.m_axis_read_desc_ready        = 1'b1;
        bus.s_axis_read_desc_status_tag   = '0;
        bus.s_axis_read_desc_status_error = '0;
        bus.s_axis_read_desc_status_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++; if (bus.m_axis_read_desc_valid !== 1'b0) begin failed++; $display("FAIL reset_desc_valid: got %0h want 0", bus.m_axis_read_desc_valid); end
        tests++; if (outstanding !== 4'd0) begin failed++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        tests++; if (stray_status !== 1'b0) begin failed++; $display("FAIL reset_stray: got %0h want 0", stray_status); end
        tests++; if (bus.m_axis_status_valid !== 2'b00) begin failed++; $display("FAIL reset_status_valid: got %0h want 0", bus.m_axis_status_valid); end
        tests++; if (bus.s_axis_desc_ready !== 2'b00) begin failed++; $display("FAIL reset_s_ready: got %0h want 0", bus.s_axis_desc_ready); end
    endtask

    task automatic test_single();
        do_reset();
        bus.s_axis_desc_valid = 2'b01;
        #1;
        tests++; if (bus.s_axis_desc_ready !== 2'b01) begin failed++; $display("FAIL single_s_ready: got %0h want 1", bus.s_axis_desc_ready); end
        step();
        bus.s_axis_desc_valid = 2'b00;
        tests++; if (bus.m_axis_read_desc_valid !== 1'b1) begin failed++; $display("FAIL single_desc_valid: got %0h want 1", bus.m_axis_read_desc_valid); end
        tests++; if (bus.m_axis_read_desc_addr !== A0) begin failed++; $display("FAIL single_addr: got %0h want %0h", bus.m_axis_read_desc_addr, A0); end
        tests++; if (bus.m_axis_read_desc_len !== 20'd4096) begin failed++; $display("FAIL single_len: got %0d want 4096", bus.m_axis_read_desc_len); end
        tests++; if (bus.m_axis_read_desc_tag !== 8'd0) begin failed++; $display("FAIL single_tag: got %0h want 0", bus.m_axis_read_desc_tag); end
        tests++; if (outstanding !== 4'd1) begin failed++; $display("FAIL single_outstanding1: got %0d want 1", outstanding); end
        bus.s_axis_read_desc_status_tag   = 8'd0;
        bus.s_axis_read_desc_status_error = 4'd0;
        bus.s_axis_read_desc_status_valid = 1'b1;
        step();
        bus.s_axis_read_desc_status_valid = 1'b0;
        tests++; if (bus.m_axis_status_valid !== 2'b01) begin failed++; $display("FAIL single_status_valid: got %0h want 1", bus.m_axis_status_valid); end
        tests++; if (bus.m_axis_status_tag[3:0] !== 4'h3) begin failed++; $display("FAIL single_status_tag: got %0h want 3", bus.m_axis_status_tag[3:0]); end
        tests++; if (outstanding !== 4'd0) begin failed++; $display("FAIL single_outstanding0: got %0d want 0", outstanding); end
        tests++; if (bus.m_axis_read_desc_valid !== 1'b0) begin failed++; $display("FAIL single_desc_drop: got %0h want 0", bus.m_axis_read_desc_valid); end
        step();
        tests++; if (bus.m_axis_status_valid !== 2'b00) begin failed++; $display("FAIL single_status_pulse: got %0h want 0", bus.m_axis_status_valid); end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_rdy;
        logic [33:0] exp_addr;
        do_reset();
        bus.s_axis_desc_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? A0 : A1;
            #1;
            tests++; if (bus.s_axis_desc_ready !== exp_rdy) begin failed++; $display("FAIL contention_grant%0d: got %0h want %0h", k, bus.s_axis_desc_ready, exp_rdy); end
            step();
            tests++; if (bus.m_axis_read_desc_tag !== 8'(k)) begin failed++; $display("FAIL contention_tag%0d: got %0h want %0h", k, bus.m_axis_read_desc_tag, k); end
            tests++; if (bus.m_axis_read_desc_addr !== exp_addr) begin failed++; $display("FAIL contention_addr%0d: got %0h want %0h", k, bus.m_axis_read_desc_addr, exp_addr); end
        end
        bus.s_axis_desc_valid = 2'b00;
        tests++; if (outstanding !== 4'd4) begin failed++; $display("FAIL contention_outstanding: got %0d want 4", outstanding); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.m_axis_read_desc_ready = 1'b0;
        bus.s_axis_desc_valid = 2'b11;
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++; if (bus.s_axis_desc_ready !== 2'b00) begin failed++; $display("FAIL bp_s_ready%0d: got %0h want 0", k, bus.s_axis_desc_ready); end
            tests++; if (bus.m_axis_read_desc_addr !== A0 || bus.m_axis_read_desc_valid !== 1'b1) begin failed++; $display("FAIL bp_hold%0d: got addr %0h valid %0h want %0h 1", k, bus.m_axis_read_desc_addr, bus.m_axis_read_desc_valid, A0); end
            step();
        end
        bus.m_axis_read_desc_ready = 1'b1;
        #1;
        tests++; if (bus.s_axis_desc_ready !== 2'b10) begin failed++; $display("FAIL bp_release_grant: got %0h want 2", bus.s_axis_desc_ready); end
        step();
        bus.s_axis_desc_valid = 2'b00;
        tests++; if (bus.m_axis_read_desc_addr !== A1 || bus.m_axis_read_desc_tag !== 8'd1) begin failed++; $display("FAIL bp_release_desc: got addr %0h tag %0h want %0h 1", bus.m_axis_read_desc_addr, bus.m_axis_read_desc_tag, A1); end
    endtask

    task automatic test_full();
        do_reset();
        bus.s_axis_desc_tag = {4'hB, 4'hA};
        bus.s_axis_desc_valid = 2'b11;
        for (int k = 0; k < 8; k++) step();
        tests++; if (outstanding !== 4'd8) begin failed++; $display("FAIL full_outstanding: got %0d want 8", outstanding); end
        tests++; if (bus.s_axis_desc_ready !== 2'b00) begin failed++; $display("FAIL full_s_ready: got %0h want 0", bus.s_axis_desc_ready); end
        step();
        tests++; if (bus.m_axis_read_desc_valid !== 1'b0 || outstanding !== 4'd8) begin failed++; $display("FAIL full_hold: got valid %0h outstanding %0d want 0 8", bus.m_axis_read_desc_valid, outstanding); end
        bus.s_axis_read_desc_status_tag   = 8'd5;
        bus.s_axis_read_desc_status_error = DMA_ERR_BUS;
        bus.s_axis_read_desc_status_valid = 1'b1;
        #1;
        tests++; if (bus.s_axis_desc_ready !== 2'b00) begin failed++; $display("FAIL full_no_early_reuse: got %0h want 0", bus.s_axis_desc_ready); end
        step();
        bus.s_axis_read_desc_status_valid = 1'b0;
        tests++; if (bus.m_axis_status_valid !== 2'b10) begin failed++; $display("FAIL full_status_owner: got %0h want 2", bus.m_axis_status_valid); end
        tests++; if (bus.m_axis_status_tag[7:4] !== 4'hB) begin failed++; $display("FAIL full_status_tag: got %0h want b", bus.m_axis_status_tag[7:4]); end
        tests++; if (bus.m_axis_status_error[7:4] !== 4'd2) begin failed++; $display("FAIL full_status_err: got %0h want 2", bus.m_axis_status_error[7:4]); end
        tests++; if (outstanding !== 4'd7) begin failed++; $display("FAIL full_outstanding7: got %0d want 7", outstanding); end
        #1;
        tests++; if (bus.s_axis_desc_ready !== 2'b01) begin failed++; $display("FAIL full_regrant: got %0h want 1", bus.s_axis_desc_ready); end
        step();
        bus.s_axis_desc_valid = 2'b00;
        tests++; if (bus.m_axis_read_desc_tag !== 8'd5 || outstanding !== 4'd8) begin failed++; $display("FAIL full_reuse5: got tag %0h outstanding %0d want 5 8", bus.m_axis_read_desc_tag, outstanding); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        bus.s_axis_desc_valid = 2'b01;
        step();
        step();
        tests++; if (outstanding !== 4'd2) begin failed++; $display("FAIL same_pre_outstanding: got %0d want 2", outstanding); end
        bus.s_axis_read_desc_status_tag   = 8'd1;
        bus.s_axis_read_desc_status_error = DMA_ERR_NONE;
        bus.s_axis_read_desc_status_valid = 1'b1;
        step();
        bus.s_axis_read_desc_status_valid = 1'b0;
        tests++; if (outstanding !== 4'd2) begin failed++; $display("FAIL same_outstanding: got %0d want 2", outstanding); end
        tests++; if (bus.m_axis_read_desc_tag !== 8'd2) begin failed++; $display("FAIL same_new_tag: got %0h want 2", bus.m_axis_read_desc_tag); end
        tests++; if (bus.m_axis_status_valid !== 2'b01) begin failed++; $display("FAIL same_status: got %0h want 1", bus.m_axis_status_valid); end
        step();
        bus.s_axis_desc_valid = 2'b00;
        tests++; if (bus.m_axis_read_desc_tag !== 8'd1 || outstanding !== 4'd3) begin failed++; $display("FAIL same_reuse1: got tag %0h outstanding %0d want 1 3", bus.m_axis_read_desc_tag, outstanding); end
    endtask

    task automatic test_stray();
        do_reset();
        bus.s_axis_read_desc_status_tag   = 8'd9;
        bus.s_axis_read_desc_status_valid = 1'b1;
        step();
        bus.s_axis_read_desc_status_valid = 1'b0;
        tests++; if (stray_status !== 1'b1) begin failed++; $display("FAIL stray_set: got %0h want 1", stray_status); end
        tests++; if (bus.m_axis_status_valid !== 2'b00) begin failed++; $display("FAIL stray_no_pulse: got %0h want 0", bus.m_axis_status_valid); end
        step();
        tests++; if (stray_status !== 1'b1 || outstanding !== 4'd0) begin failed++; $display("FAIL stray_sticky: got %0h outstanding %0d want 1 0", stray_status, outstanding); end
        bus.s_axis_desc_valid = 2'b11;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        tests++; if (bus.m_axis_read_desc_valid !== 1'b0 || outstanding !== 4'd0) begin failed++; $display("FAIL midrst_clear: got valid %0h outstanding %0d want 0 0", bus.m_axis_read_desc_valid, outstanding); end
        tests++; if (stray_status !== 1'b0 || bus.m_axis_status_valid !== 2'b00) begin failed++; $display("FAIL midrst_flags: got stray %0h status %0h want 0 0", stray_status, bus.m_axis_status_valid); end
        tests++; if (bus.s_axis_desc_ready !== 2'b00) begin failed++; $display("FAIL midrst_s_ready: got %0h want 0", bus.s_axis_desc_ready); end
        rst = 1'b0;
        bus.s_axis_desc_valid = 2'b00;
        bus.s_axis_read_desc_status_tag   = 8'd0;
        bus.s_axis_read_desc_status_valid = 1'b1;
        step();
        bus.s_axis_read_desc_status_valid = 1'b0;
        tests++; if (stray_status !== 1'b1 || bus.m_axis_status_valid !== 2'b00) begin failed++; $display("FAIL midrst_late_status: got stray %0h status %0h want 1 0", stray_status, bus.m_axis_status_valid); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_full();
        test_same_cycle();
        test_stray();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
